// File: rtl/otter_bus_interconnect.sv
// Single-master, N-slave OTTER bus interconnect: address decode, registered slave request,
// response routing, error completion for unmapped/illegal accesses, hung-slave watchdog.
//
// state | meaning
// IDLE  | waiting for a master request
// BUSY  | request driven to the selected slave, waiting for its ack
// RESP  | one-cycle m_ack completion
// ERR   | one-cycle m_err completion (unmapped, rd&wr, or timeout)
module otter_bus_interconnect #(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h1100_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_0000},
  parameter int TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  input  logic                       m_rd,
  input  logic                       m_wr,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_ack,
  output logic                       m_err,
  output logic [N_SLAVES-1:0]        s_sel,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  output logic                       s_rd,
  output logic                       s_wr,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_ack,
  output logic [15:0]                err_cnt
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]    TMO_LOAD = TMO_W'(TIMEOUT - 1);
  localparam logic [N_SLAVES-1:0] SEL_ONE  = N_SLAVES'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] sel_idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [15:0]      err_cnt_inc;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign err_cnt_inc = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
  assign m_ack = (state == ST_RESP);
  assign m_err = (state == ST_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_idx <= '0;
      tmo_cnt <= '0;
      s_sel   <= '0;
      s_rd    <= 1'b0;
      s_wr    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      m_rdata <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_rd || m_wr) begin
            if ((m_rd && m_wr) || !hit) begin
              m_rdata <= '0;
              err_cnt <= err_cnt_inc;
              state   <= ST_ERR;
            end else begin
              s_addr  <= m_addr;
              s_wdata <= m_wdata;
              s_wstrb <= m_wstrb;
              s_sel   <= SEL_ONE << hit_idx;
              s_rd    <= m_rd;
              s_wr    <= m_wr;
              sel_idx <= hit_idx;
              tmo_cnt <= TMO_LOAD;
              state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (s_ack[sel_idx]) begin
            m_rdata <= s_rdata[sel_idx*DATA_W +: DATA_W];
            s_sel   <= '0;
            s_rd    <= 1'b0;
            s_wr    <= 1'b0;
            state   <= ST_RESP;
          end else if (tmo_cnt == '0) begin
            m_rdata <= '0;
            s_sel   <= '0;
            s_rd    <= 1'b0;
            s_wr    <= 1'b0;
            err_cnt <= err_cnt_inc;
            state   <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_bus_interconnect.sv
// Directed bench for otter_bus_interconnect with default parameters; bench drives and samples
// on the falling edge, slaves are modelled inline by the stimulus sequence.
module tb_otter_bus_interconnect;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_rd, m_wr, m_ack, m_err;
  logic [1:0]  s_sel, s_ack;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_rd, s_wr;
  logic [63:0] s_rdata;
  logic [15:0] err_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  otter_bus_interconnect #(
    .N_SLAVES(2), .ADDR_W(32), .DATA_W(32),
    .SLV_BASE({32'h1100_0000, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_FF00, 32'hFFFF_0000}),
    .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rd(s_rd), .s_wr(s_wr),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; m_addr = '0; m_wdata = '0; m_wstrb = '0; m_rd = 1'b0; m_wr = 1'b0;
    s_rdata = '0; s_ack = '0;
    cyc(); cyc();
    check("rst_ack", m_ack, 0);
    check("rst_err", m_err, 0);
    check("rst_sel", s_sel, 0);
    check("rst_rdwr", {s_rd, s_wr}, 0);
    check("rst_rdata", m_rdata, 0);
    check("rst_errcnt", err_cnt, 0);
    rst = 1'b0;
    cyc();

    // read from SRAM window, slave0 acks in cycle 1
    m_rd = 1'b1; m_addr = 32'h0000_0040;
    cyc();
    check("rd_sel_c1", s_sel, 2'b01);
    check("rd_srd_c1", {s_rd, s_wr}, 2'b10);
    check("rd_saddr_c1", s_addr, 32'h0000_0040);
    check("rd_ack_c1", m_ack, 0);
    s_ack = 2'b01; s_rdata = {32'hDEAD_BEEF, 32'hCAFE_F00D};
    cyc();
    check("rd_ack_c2", m_ack, 1);
    check("rd_err_c2", m_err, 0);
    check("rd_rdata_c2", m_rdata, 32'hCAFE_F00D);
    check("rd_sel_c2", s_sel, 0);
    m_rd = 1'b0; s_ack = 2'b00;
    cyc();
    check("rd_ack_c3", m_ack, 0);

    // write to MMIO window, slave1 acks after 3 wait cycles; stray slave0 ack ignored
    m_wr = 1'b1; m_addr = 32'h1100_0004; m_wdata = 32'h0000_00A5; m_wstrb = 4'b0001;
    s_rdata = {32'h1234_5678, 32'h0000_0000};
    for (int c = 1; c <= 4; c++) begin
      cyc();
      s_ack = 2'b00;
      check("wr_sel", s_sel, 2'b10);
      check("wr_swr", {s_rd, s_wr}, 2'b01);
      check("wr_payload", {s_wdata, s_addr}, {32'h0000_00A5, 32'h1100_0004});
      check("wr_wstrb", s_wstrb, 4'b0001);
      check("wr_no_ack", {m_ack, m_err}, 0);
      if (c == 2) s_ack = 2'b01;
      if (c == 4) s_ack = 2'b10;
    end
    cyc();
    check("wr_ack", m_ack, 1);
    check("wr_swr_after", s_wr, 0);
    check("wr_sel_after", s_sel, 0);
    m_wr = 1'b0; s_ack = 2'b00;
    cyc();
    check("wr_ack_single", m_ack, 0);

    // unmapped read
    m_rd = 1'b1; m_addr = 32'h2000_0000;
    cyc();
    check("um_err", m_err, 1);
    check("um_ack", m_ack, 0);
    check("um_rdata", m_rdata, 0);
    check("um_sel", s_sel, 0);
    m_rd = 1'b0;
    cyc();
    check("um_err_single", m_err, 0);
    check("um_errcnt", err_cnt, 1);

    // hung slave0: strobes for exactly 16 cycles, m_err in cycle 17
    m_rd = 1'b1; m_addr = 32'h0000_0100;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      check("to_srd_high", {s_rd, s_sel}, {1'b1, 2'b01});
      check("to_no_done", {m_ack, m_err}, 0);
    end
    cyc();
    check("to_err_c17", m_err, 1);
    check("to_srd_c17", {s_rd, s_sel}, 0);
    m_rd = 1'b0;
    cyc();
    check("to_errcnt", err_cnt, 2);
    for (int c = 0; c < 3; c++) cyc();
    s_ack = 2'b01;
    cyc();
    s_ack = 2'b00;
    check("late_ack_ignored", {m_ack, m_err}, 0);
    cyc();
    check("late_ack_ignored2", {m_ack, m_err}, 0);

    // rd and wr together
    m_rd = 1'b1; m_wr = 1'b1; m_addr = 32'h0000_0040;
    cyc();
    check("both_err", m_err, 1);
    check("both_noslave", {s_sel, s_rd, s_wr}, 0);
    m_rd = 1'b0; m_wr = 1'b0;
    cyc();
    check("both_errcnt", err_cnt, 3);

    // reset during a slave1 wait
    m_rd = 1'b1; m_addr = 32'h1100_0010;
    cyc();
    check("rb_sel", s_sel, 2'b10);
    cyc();
    rst = 1'b1;
    cyc();
    check("rb_outs", {s_sel, s_rd, s_wr, m_ack, m_err}, 0);
    check("rb_data", {m_rdata, s_addr}, 0);
    check("rb_errcnt", err_cnt, 0);
    rst = 1'b0; m_rd = 1'b0; s_ack = 2'b10;
    cyc();
    s_ack = 2'b00;
    check("rb_late_ack", {m_ack, m_err, s_sel}, 0);
    m_rd = 1'b1; m_addr = 32'h1100_0020;
    cyc();
    check("rb_rd_sel", s_sel, 2'b10);
    s_ack = 2'b10; s_rdata = {32'h5A5A_1234, 32'hFFFF_FFFF};
    cyc();
    check("rb_rd_ack", {m_ack, m_err}, 2'b10);
    check("rb_rd_data", m_rdata, 32'h5A5A_1234);
    m_rd = 1'b0; s_ack = 2'b00;
    cyc();

    // saturation: preset the counter near the top, then drive errors
    force dut.err_cnt = 16'hFFFD;
    cyc();
    release dut.err_cnt;
    cyc();
    for (int e = 0; e < 3; e++) begin
      m_rd = 1'b1; m_addr = 32'h2000_0000;
      cyc();
      check("sat_err", m_err, 1);
      m_rd = 1'b0;
      cyc();
      check("sat_cnt", err_cnt, (e == 0) ? 16'hFFFE : 16'hFFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
